data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 176 +++++++++++++++++
 tb/tb_data_memory.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Word-addressed data memory with RV32I byte/half/word access, fixed LATENCY response and error screening.
// One request in flight; req_ready only when idle, response held until resp_ready.
module data_memory #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } req_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          acc_err;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   ld_data;
  logic          mem_we;

  // Access decode works entirely off the captured request, so live inputs are ignored after acceptance.
  always_comb begin
    word_idx = req_q.addr[AW+1:2];
    lane     = req_q.addr[1:0];

    acc_err = 1'b0;
    if ({1'b0, req_q.addr} >= ADDR_LIMIT) acc_err = 1'b1;
    case (req_q.funct3)
      F3_B, F3_BU: ;
      F3_H, F3_HU: if (lane[0]) acc_err = 1'b1;
      F3_W:        if (lane != 2'b00) acc_err = 1'b1;
      default:     acc_err = 1'b1;
    endcase
    if (req_q.write && req_q.funct3[2]) acc_err = 1'b1;

    // Store data is replicated across lanes so the byte enables alone pick the target lanes.
    wr_be   = 4'b0000;
    wr_data = '0;
    case (req_q.funct3[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << lane;
        wr_data = {4{req_q.wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_q.wdata[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = req_q.wdata;
      end
    endcase

    rd_word = mem_q[word_idx];
    rd_byte = rd_word[{lane, 3'b000} +: 8];
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    case (req_q.funct3)
      F3_B:    ld_data = {{24{rd_byte[7]}}, rd_byte};
      F3_BU:   ld_data = {24'h0, rd_byte};
      F3_H:    ld_data = {{16{rd_half[15]}}, rd_half};
      F3_HU:   ld_data = {16'h0, rd_half};
      F3_W:    ld_data = rd_word;
      default: ld_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    error_d = error_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_d.write  = req_write;
          req_d.addr   = req_addr;
          req_d.wdata  = req_wdata;
          req_d.funct3 = req_funct3;
          cnt_d        = 4'(LATENCY - 1);
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          error_d = acc_err;
          rdata_d = (acc_err || req_q.write) ? 32'h0 : ld_data;
          mem_we  = req_q.write && !acc_err;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage is never reset; a reset edge only suppresses a commit that would land on it.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_rdata = rdata_q;
    resp_error = error_q;
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: expected responses queued at issue, compared when resp_valid appears.
module tb_data_memory;

  localparam int LATENCY = 2;
  localparam int DEPTH   = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mb [0:31];

  data_memory #(.DEPTH_WORDS(DEPTH), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_exp(input logic [31:0] rd, input logic er);
    exp_t e;
    e.rdata = rd;
    e.err   = er;
    sb.push_back(e);
  endtask

  // Drives one request and returns #1 after its acceptance edge, scrambling the don't-care inputs.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    int n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_funct3 = f3;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%0b want 1", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom);
  endtask

  task automatic collect();
    int   k;
    exp_t e;
    k = 0;
    @(negedge clk);
    while (!resp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== LATENCY) begin
      errors++;
      $display("FAIL latency: edges=%0d want %0d", k, LATENCY);
    end
    if (!resp_valid || sb.size() == 0) begin
      errors++;
      $display("FAIL resp_missing: resp_valid=%0b queued=%0d", resp_valid, sb.size());
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    checks++;
    if (resp_rdata !== e.rdata) begin
      errors++;
      $display("FAIL rdata: got %08h want %08h", resp_rdata, e.rdata);
    end
    checks++;
    if (resp_error !== e.err) begin
      errors++;
      $display("FAIL error_flag: got %0b want %0b", resp_error, e.err);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL return_idle: resp_valid=%0b req_ready=%0b want 0/1", resp_valid, req_ready);
    end
  endtask

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                     input logic [31:0] rd, input logic er);
    push_exp(rd, er);
    issue(w, a, d, f3);
    collect();
  endtask

  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                       output exp_t e);
    logic [4:0]  o;
    logic        bad;
    logic [31:0] v;
    o   = 5'(a - 32'h100);
    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (w && f3[2]) ||
          ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
    e.rdata = 32'h0;
    e.err   = bad;
    if (!bad) begin
      if (w) begin
        mb[o] = d[7:0];
        if (f3[1:0] != 2'b00) mb[o+5'd1] = d[15:8];
        if (f3[1:0] == 2'b10) begin
          mb[o+5'd2] = d[23:16];
          mb[o+5'd3] = d[31:24];
        end
      end else begin
        case (f3[1:0])
          2'b00:   v = f3[2] ? {24'h0, mb[o]} : {{24{mb[o][7]}}, mb[o]};
          2'b01:   v = f3[2] ? {16'h0, mb[o+5'd1], mb[o]} : {{16{mb[o+5'd1][7]}}, mb[o+5'd1], mb[o]};
          default: v = {mb[o+5'd3], mb[o+5'd2], mb[o+5'd1], mb[o]};
        endcase
        e.rdata = v;
      end
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_error !== 1'b0 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b err=%0b rdata=%08h want 0/0/0", resp_valid, resp_error, resp_rdata);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%0b want 1", req_ready);
    end
  endtask

  task automatic test_word();
    txn(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
    txn(1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_subword_load();
    txn(1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFFDE, 1'b0);
    txn(1'b0, 32'h13, 32'h0, 3'b100, 32'h000000DE, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0);
    txn(1'b0, 32'h12, 32'h0, 3'b101, 32'h0000DEAD, 1'b0);
  endtask

  task automatic test_subword_store();
    txn(1'b1, 32'h11, 32'h000000AA, 3'b000, 32'h0, 1'b0);
    txn(1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADAAEF, 1'b0);
    txn(1'b1, 32'h12, 32'hFFFF1234, 3'b001, 32'h0, 1'b0);
    txn(1'b0, 32'h10, 32'h0,        3'b010, 32'h1234AAEF, 1'b0);
  endtask

  task automatic test_errors();
    txn(1'b0, 32'h12,   32'h0,        3'b010, 32'h0, 1'b1);
    txn(1'b1, 32'h11,   32'h5555AAAA, 3'b001, 32'h0, 1'b1);
    txn(1'b0, 32'h1000, 32'h0,        3'b010, 32'h0, 1'b1);
    txn(1'b0, 32'h10,   32'h0,        3'b011, 32'h0, 1'b1);
    txn(1'b1, 32'h10,   32'h000000CC, 3'b100, 32'h0, 1'b1);
    txn(1'b1, 32'h1000, 32'h77777777, 3'b010, 32'h0, 1'b1);
    txn(1'b0, 32'h10,   32'h0,        3'b010, 32'h1234AAEF, 1'b0);
    txn(1'b1, 32'hFFC,  32'h55AA1234, 3'b010, 32'h0, 1'b0);
    txn(1'b0, 32'hFFF,  32'h0,        3'b000, 32'h00000055, 1'b0);
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   k;
    push_exp(32'h1234AAEF, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 3'b010);
    k = 0;
    @(negedge clk);
    while (!resp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    e = sb.pop_front();
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 32'h10;
    req_wdata  = 32'h0;
    req_funct3 = 3'b010;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_error !== e.err || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%0b rdata=%08h err=%0b ready=%0b want 1/%08h/%0b/0",
                 i, resp_valid, resp_rdata, resp_error, req_ready, e.rdata, e.err);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: valid=%0b ready=%0b want 0/1", resp_valid, req_ready);
    end
    txn(1'b0, 32'h10, 32'h0, 3'b010, 32'h1234AAEF, 1'b0);
  endtask

  task automatic test_reset_in_wait();
    logic seen;
    txn(1'b1, 32'h20, 32'h0BADF00D, 3'b010, 32'h0, 1'b0);
    issue(1'b1, 32'h20, 32'h12345678, 3'b010);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait_state: valid=%0b ready=%0b want 0/1", resp_valid, req_ready);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait_noresp: resp_valid seen=%0b want 0", seen);
    end
    txn(1'b0, 32'h20, 32'h0, 3'b010, 32'h0BADF00D, 1'b0);
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f3;
    for (int i = 0; i < 8; i++) begin
      a = 32'h100 + 32'(4 * i);
      d = $urandom;
      model(1'b1, a, d, 3'b010, e);
      txn(1'b1, a, d, 3'b010, e.rdata, e.err);
    end
    for (int i = 0; i < 40; i++) begin
      w  = 1'($urandom_range(0, 1));
      a  = 32'h100 + 32'($urandom_range(0, 31));
      d  = $urandom;
      f3 = 3'($urandom_range(0, 7));
      model(w, a, d, f3, e);
      txn(w, a, d, f3, e.rdata, e.err);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword_load();
    test_subword_store();
    test_errors();
    test_backpressure();
    test_reset_in_wait();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
